// File: rtl/dds_mixer.sv
// Down-converting complex mixer behind the dds oscillator: y = x * (cos - j*sin).
// Build macro DDS_MIXER_ROUND_EN selects round-half-up scaling; otherwise floor.
module dds_mixer #(
  parameter int pDAT_W = 16,
  parameter int pDDS_W = 14,
  parameter int pOUT_W = 16,
  parameter int pDLY   = 6
) (
  input  logic                     iclk,
  input  logic                     ireset,
  input  logic                     iclkena,
  input  logic                     ival,
  input  logic signed [pDAT_W-1:0] idat_re,
  input  logic signed [pDAT_W-1:0] idat_im,
  input  logic signed [pDDS_W-1:0] isin,
  input  logic signed [pDDS_W-1:0] icos,
  output logic                     odds_clkena,
  input  logic                     iclr_sat,
  output logic                     oval,
  output logic signed [pOUT_W-1:0] odat_re,
  output logic signed [pOUT_W-1:0] odat_im,
  output logic                     osat
);

  localparam int CNT_W = $clog2(pDLY + 1);
  localparam int PW    = pDAT_W + pDDS_W;
  localparam int SW    = PW + 1;
  localparam int RW    = SW + 1;
  localparam int SH    = pDDS_W - 1;
  localparam int QW    = RW - SH;
  localparam logic signed [QW-1:0] OMAX = QW'((2 ** (pOUT_W - 1)) - 1);
  localparam logic signed [QW-1:0] OMIN = QW'(-(2 ** (pOUT_W - 1)));
`ifdef DDS_MIXER_ROUND_EN
  localparam logic signed [RW-1:0] RND = RW'(1) << (SH - 1);
`endif

  // ival is valid-only (no ready): a sample is taken in every cycle with
  // iclkena & ival, and the oscillator is stepped in exactly those cycles.
  logic accept, pop;
  logic [CNT_W-1:0] fill_cnt;
  logic signed [pDAT_W-1:0] dl_re [pDLY];
  logic signed [pDAT_W-1:0] dl_im [pDLY];

  assign accept      = iclkena & ival;
  assign odds_clkena = accept;
  assign pop         = accept && (fill_cnt == CNT_W'(pDLY));

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      fill_cnt <= '0;
      for (int i = 0; i < pDLY; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else if (accept) begin
      dl_re[0] <= idat_re;
      dl_im[0] <= idat_im;
      for (int i = 1; i < pDLY; i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
      if (fill_cnt != CNT_W'(pDLY)) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Tail of the delay line meets the oscillator output of the current accept.
  logic s1_val, s2_val;
  logic signed [PW-1:0] p_rc, p_is, p_ic, p_rs;
  logic signed [SW-1:0] s2_re, s2_im;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      s1_val <= 1'b0;
      s2_val <= 1'b0;
      p_rc   <= '0;
      p_is   <= '0;
      p_ic   <= '0;
      p_rs   <= '0;
      s2_re  <= '0;
      s2_im  <= '0;
    end else if (iclkena) begin
      s1_val <= pop;
      s2_val <= s1_val;
      if (pop) begin
        p_rc <= PW'(dl_re[pDLY-1]) * PW'(icos);
        p_is <= PW'(dl_im[pDLY-1]) * PW'(isin);
        p_ic <= PW'(dl_im[pDLY-1]) * PW'(icos);
        p_rs <= PW'(dl_re[pDLY-1]) * PW'(isin);
      end
      if (s1_val) begin
        s2_re <= SW'(p_rc) + SW'(p_is);
        s2_im <= SW'(p_ic) - SW'(p_rs);
      end
    end
  end

  // Returns {clipped, value}: scale by 2^-(pDDS_W-1), then clamp to pOUT_W.
  function automatic logic [pOUT_W:0] scale_sat(input logic signed [SW-1:0] v);
    logic signed [RW-1:0] r;
    logic signed [QW-1:0] q;
    logic [pOUT_W:0] res;
    r = RW'(v);
`ifdef DDS_MIXER_ROUND_EN
    r = r + RND;
`endif
    q = QW'(r >>> SH);
    res = {1'b0, q[pOUT_W-1:0]};
    if (q > OMAX) res = {1'b1, OMAX[pOUT_W-1:0]};
    else if (q < OMIN) res = {1'b1, OMIN[pOUT_W-1:0]};
    return res;
  endfunction

  logic [pOUT_W:0] res_re, res_im;
  assign res_re = scale_sat(s2_re);
  assign res_im = scale_sat(s2_im);

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      oval    <= 1'b0;
      odat_re <= '0;
      odat_im <= '0;
      osat    <= 1'b0;
    end else begin
      oval <= iclkena & s2_val;
      if (iclkena) begin
        if (s2_val) begin
          odat_re <= res_re[pOUT_W-1:0];
          odat_im <= res_im[pOUT_W-1:0];
        end
        // A clip in the same cycle as a clear request keeps the flag set.
        if (s2_val && (res_re[pOUT_W] || res_im[pOUT_W])) osat <= 1'b1;
        else if (iclr_sat) osat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dds_mixer.sv
// Bench for dds_mixer: table vectors, fill/latency, saturation, stall, reset and
// randomized traffic checked against a sample-queue model of the mixer.
module tb_dds_mixer;

  localparam int DAT_W = 16;
  localparam int DDS_W = 14;
  localparam int OUT_W = 16;
  localparam int DLY   = 6;
`ifdef DDS_MIXER_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic                    iclk = 1'b0;
  logic                    ireset = 1'b0;
  logic                    iclkena = 1'b0;
  logic                    ival = 1'b0;
  logic signed [DAT_W-1:0] idat_re = '0;
  logic signed [DAT_W-1:0] idat_im = '0;
  logic signed [DDS_W-1:0] isin = '0;
  logic signed [DDS_W-1:0] icos = '0;
  logic                    iclr_sat = 1'b0;
  logic                    odds_clkena;
  logic                    oval;
  logic signed [OUT_W-1:0] odat_re;
  logic signed [OUT_W-1:0] odat_im;
  logic                    osat;

  dds_mixer #(.pDAT_W(DAT_W), .pDDS_W(DDS_W), .pOUT_W(OUT_W), .pDLY(DLY)) dut (
    .iclk        (iclk),
    .ireset      (ireset),
    .iclkena     (iclkena),
    .ival        (ival),
    .idat_re     (idat_re),
    .idat_im     (idat_im),
    .isin        (isin),
    .icos        (icos),
    .odds_clkena (odds_clkena),
    .iclr_sat    (iclr_sat),
    .oval        (oval),
    .odat_re     (odat_re),
    .odat_im     (odat_im),
    .osat        (osat)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 iclk = ~iclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int oval_cnt = 0;
  bit sat_seen = 1'b0;

  always @(posedge iclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  function automatic logic [2*OUT_W:0] ref_mix(input int xr, input int xi,
                                               input int s, input int c);
    longint re, im, hi, lo;
    bit clip;
    re = longint'(xr) * c + longint'(xi) * s;
    im = longint'(xi) * c - longint'(xr) * s;
    if (ROUND) begin
      re = re + (longint'(1) << (DDS_W - 2));
      im = im + (longint'(1) << (DDS_W - 2));
    end
    re = re >>> (DDS_W - 1);
    im = im >>> (DDS_W - 1);
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    clip = (re > hi) || (re < lo) || (im > hi) || (im < lo);
    if (re > hi) re = hi;
    if (re < lo) re = lo;
    if (im > hi) im = hi;
    if (im < lo) im = lo;
    return {clip, OUT_W'(re), OUT_W'(im)};
  endfunction

  logic [2*DAT_W-1:0] acc_q[$];
  logic [2*OUT_W:0]   exp_q[$];

  // Every accepted sample is queued; once DLY older samples exist, the oldest
  // is mixed with the oscillator value presented alongside the new accept.
  always @(posedge iclk) begin
    logic [2*DAT_W-1:0] t;
    if (!ireset) begin
      acc_q.delete();
      exp_q.delete();
    end else if (iclkena && ival) begin
      acc_q.push_back({idat_re, idat_im});
      if (acc_q.size() > DLY) begin
        t = acc_q.pop_front();
        exp_q.push_back(ref_mix(int'($signed(t[2*DAT_W-1:DAT_W])),
                                int'($signed(t[DAT_W-1:0])),
                                int'(isin), int'(icos)));
      end
    end
  end

  always @(negedge iclk) begin
    logic [2*OUT_W:0] e;
    if (ireset) begin
      check("dds_clkena", odds_clkena, iclkena & ival);
      if (oval === 1'b1) begin
        oval_cnt++;
        if (exp_q.size() == 0) begin
          check("oval_unexpected", oval, 0);
        end else begin
          e = exp_q.pop_front();
          check("mon_re", odat_re, $signed(e[2*OUT_W-1:OUT_W]));
          check("mon_im", odat_im, $signed(e[OUT_W-1:0]));
          if (e[2*OUT_W]) sat_seen = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int rnd_dat();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int rnd_lo();
    return int'($urandom_range(0, 16382)) - 8191;
  endfunction

  task automatic drive(input bit ena, input bit val, input int re, input int im,
                       input int s, input int c, input bit clr);
    @(posedge iclk);
    #1;
    iclkena  = ena;
    ival     = val;
    idat_re  = DAT_W'(re);
    idat_im  = DAT_W'(im);
    isin     = DDS_W'(s);
    icos     = DDS_W'(c);
    iclr_sat = clr;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge iclk);
    #3;
    ireset  = 1'b0;
    iclkena = 1'b0;
    ival    = 1'b0;
    iclr_sat = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    ireset   = 1'b1;
    sat_seen = 1'b0;
  endtask

  task automatic wait_oval(output int got_cyc, output bit ok);
    ok = 1'b0;
    got_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge iclk);
      if (oval === 1'b1) begin
        ok = 1'b1;
        got_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic fill_test(input string tag);
    int k, got, base;
    bit ok;
    base = oval_cnt;
    for (int i = 0; i < DLY + 1; i++) drive(1'b1, 1'b1, rnd_dat(), rnd_dat(), rnd_lo(), rnd_lo(), 1'b0);
    k = cyc;
    idle();
    wait_oval(got, ok);
    check({tag, "_oval_seen"}, ok, 1);
    check({tag, "_latency"}, got - k, 3);
    repeat (3) idle();
    check({tag, "_single_oval"}, oval_cnt - base, 1);
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    string name;
    int re, im, s, c;
    int exp_re, exp_im;
    bit exp_sat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int got, vre, vim;
    bit ok;
    logic signed [OUT_W-1:0] hold_re, hold_im;

    vecs[0] = '{"unit_cos",   1000, -2000, 0,    8191,  ROUND ? 1000 : 999, -2000, 1'b0};
    vecs[1] = '{"quadrature", 1000, 0,     8191, 0,     0, -1000, 1'b0};
    vecs[2] = '{"sat_pos",    32767, 32767, 8191, 8191,  32767, 0, 1'b1};
    vecs[3] = '{"sat_neg",    -32768, -32768, 8191, 8191, -32768, 0, 1'b1};
    vecs[4] = '{"mixed",      -1000, 500,  4096, -4096, 750, 250, 1'b0};
    vecs[5] = '{"half_pos",   1, 0,        0,    4096,  ROUND ? 1 : 0, 0, 1'b0};
    vecs[6] = '{"half_neg",   -1, 0,       0,    4096,  ROUND ? 0 : -1, 0, 1'b0};

    // Reset state while ireset is held from time zero.
    #2;
    check("rst_oval", oval, 0);
    check("rst_re", odat_re, 0);
    check("rst_im", odat_im, 0);
    check("rst_osat", osat, 0);
    check("rst_dds_clkena", odds_clkena, 0);
    do_reset();

    fill_test("fill");

    foreach (vecs[v]) begin
      do_reset();
      for (int i = 0; i < DLY + 1; i++)
        drive(1'b1, 1'b1, vecs[v].re, vecs[v].im, vecs[v].s, vecs[v].c, 1'b0);
      idle();
      wait_oval(got, ok);
      vre = int'(odat_re);
      vim = int'(odat_im);
      check({vecs[v].name, "_seen"}, ok, 1);
      check({vecs[v].name, "_re"}, vre, vecs[v].exp_re);
      check({vecs[v].name, "_im"}, vim, vecs[v].exp_im);
      check({vecs[v].name, "_sat"}, osat, vecs[v].exp_sat);
    end

    // Sticky saturation: ignored clear while stalled, then a real clear.
    do_reset();
    for (int i = 0; i < DLY + 1; i++) drive(1'b1, 1'b1, 32767, 32767, 8191, 8191, 1'b0);
    idle();
    wait_oval(got, ok);
    check("sat_seq_seen", ok, 1);
    repeat (3) begin
      idle();
      @(negedge iclk);
      check("sat_sticky", osat, 1);
    end
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    idle();
    @(negedge iclk);
    check("sat_clr_stalled", osat, 1);
    drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
    @(negedge iclk);
    check("sat_clr_same_cycle", osat, 1);
    idle();
    @(negedge iclk);
    check("sat_cleared", osat, 0);

    // Stall mid-stream: the model is stall-agnostic, so any loss shows up there.
    do_reset();
    repeat (20) drive(1'b1, 1'b1, rnd_dat(), rnd_dat(), rnd_lo(), rnd_lo(), 1'b0);
    drive(1'b0, 1'b1, rnd_dat(), rnd_dat(), rnd_lo(), rnd_lo(), 1'b0);
    @(negedge iclk);
    hold_re = odat_re;
    hold_im = odat_im;
    repeat (4) begin
      drive(1'b0, 1'b1, rnd_dat(), rnd_dat(), rnd_lo(), rnd_lo(), 1'b0);
      @(negedge iclk);
      check("stall_oval", oval, 0);
      check("stall_hold_re", odat_re, hold_re);
      check("stall_hold_im", odat_im, hold_im);
    end
    repeat (15) drive(1'b1, 1'b1, rnd_dat(), rnd_dat(), rnd_lo(), rnd_lo(), 1'b0);
    repeat (8) idle();
    check("stall_drained", exp_q.size(), 0);

    // Randomized traffic with random stalls and bubbles.
    do_reset();
    repeat (400)
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            rnd_dat(), rnd_dat(), rnd_lo(), rnd_lo(), 1'b0);
    repeat (8) idle();
    check("rand_drained", exp_q.size(), 0);
    check("rand_osat", osat, sat_seen);

    // Asynchronous reset mid-stream, then a full refill is needed.
    repeat (12) drive(1'b1, 1'b1, 32767, -32768, rnd_lo(), rnd_lo(), 1'b0);
    @(posedge iclk);
    #3;
    ireset = 1'b0;
    #1;
    check("arst_oval", oval, 0);
    check("arst_re", odat_re, 0);
    check("arst_im", odat_im, 0);
    check("arst_osat", osat, 0);
    iclkena = 1'b0;
    ival = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    ireset = 1'b1;
    sat_seen = 1'b0;
    fill_test("refill");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_mixer.md
# dds_mixer

Complex digital mixer placed directly downstream of the `dds` oscillator. Each accepted complex sample is multiplied by the conjugate local-oscillator phasor (cos − j·sin): x·e^(−jωn), i.e. down-conversion. The block drives the oscillator's clock enable so the oscillator advances exactly once per accepted sample. An internal delay line aligns each sample with the oscillator's pipeline latency, and the result is rounded and saturated to the output width.

## Interface
- pDAT_W, 16, input sample width (signed I/Q)
- pDDS_W, 14, oscillator sin/cos width (signed; full scale ±(2^(pDDS_W−1)−1))
- pOUT_W, 16, output sample width (signed)
- pDLY, 6, oscillator latency in enabled ticks (must be ≥1)

- iclk  in  1  clock
- ireset  in  1  reset; asynchronous, active-low
- iclkena  in  1  global clock enable; all state holds when low
- ival  in  1  input sample valid
- idat_re / idat_im  in  pDAT_W each  input sample I/Q
- isin / icos  in  pDDS_W each  oscillator outputs
- odds_clkena  out  1  combinational iclkena & ival; drives the oscillator's iclkena
- iclr_sat  in  1  clears osat (synchronous, gated by iclkena)
- oval  out  1  output valid, one-cycle pulse per result
- odat_re / odat_im  out  pDAT_W... pOUT_W each  mixed result
- osat  out  1  sticky saturation flag

## Operation
- Accept: a cycle with iclkena=1 and ival=1 (the odds_clkena cycle).
- Delay line:
  - pDLY-entry shift register of {re, im}, shifted on accept.
  - Fill counter 0..pDLY, saturating.
  - Pop: an accept with counter==pDLY. The tail entry (the sample accepted pDLY accepts earlier) is paired with isin/icos sampled in the same cycle.
  - The first pDLY accepts after reset are discarded and produce no output.
- Stage 1, on pop: register the four products xr·cos, xi·sin, xi·cos, xr·sin, each pDAT_W+pDDS_W bits signed. Stage 1 valid = pop.
- Stage 2: re = xr·cos + xi·sin; im = xi·cos − xr·sin. Each is pDAT_W+pDDS_W+1 bits, with no overflow possible.
- Stage 3: scale by 2^−(pDDS_W−1) (rounding per Configuration), then saturate to [−2^(pOUT_W−1), 2^(pOUT_W−1)−1].
  - If either component clips, set osat.
  - osat stays high until iclr_sat=1 with iclkena=1.
  - If saturation and clear occur in the same cycle, set wins.
- Stage valid registers and data registers advance only when iclkena=1.
- oval is registered every cycle as iclkena & stage-3-valid. It never repeats during a stall.
- odat_* hold their last value between pulses.

## Timing
- Reset: all outputs 0 (oval=0, odat_re=odat_im=0, osat=0); delay line, fill counter and stage valids cleared.
- Reset mid-stream: all in-flight samples are dropped, and refill restarts at 0. The oscillator phase is not the mixer's responsibility.
- Latency, with iclkena held high: a pop at cycle k gives oval=1 in cycle k+3.
- Throughput: one result per clock; ival may stay high indefinitely.
- A stall (iclkena=0) freezes every register except oval, which goes low. The pipeline resumes without loss.
- ival=0 with iclkena=1: odds_clkena=0, the delay line holds, and bubbles propagate through the pipeline.

## Configuration
- DDS_MIXER_ROUND_EN:
  - Defined: round half-up, i.e. add 2^(pDDS_W−2), then arithmetic shift right by pDDS_W−1.
  - Undefined: plain arithmetic shift right (floor).
  - Saturation behaviour is identical in both cases.

## Test plan
All scenarios use default parameters.
- Fill/latency: 6 accepts produce no oval. The 7th accept at cycle k gives oval in cycle k+3, and odds_clkena mirrors every accept.
- Unit cos:
  - Stimulus: x=(1000, −2000), icos=8191, isin=0.
  - ROUND_EN: out=(1000, −2000).
  - Without ROUND_EN: out=(999, −2000).
- Quadrature:
  - Stimulus: x=(1000, 0), icos=0, isin=8191.
  - ROUND_EN: out=(0, −1000).
  - Without ROUND_EN: out=(0, −1000).
- Saturation:
  - Stimulus: x=(32767, 32767), icos=isin=8191.
  - Response: out=(32767, 0) and osat=1. osat stays 1 until an iclr_sat pulse, then drops to 0 the next cycle.
- Stall: drop iclkena for 5 cycles mid-stream. oval=0 and odat_* are held during the stall. The result sequence afterwards equals the unstalled reference exactly.
- Reset: assert ireset low mid-stream, asynchronously between edges. All outputs are 0 immediately. After release, 6 accepts are needed again before any oval.
